// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding and stream framing sizes.
package loader_pkg;

   typedef enum logic [2:0] {
      HDR0,
      HDR1,
      DATA,
      CSUM,
      RUN,
      ERR
   } state_e;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
// word_valid_o pulses with the 4th byte; the top registers it.
module byte_packer
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        clr_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   localparam logic [1:0] LAST = 2'(WORD_BYTES - 1);

   logic [1:0]  bcnt_q;
   logic [23:0] buf_q;

   assign word_valid_o = byte_valid_i && (bcnt_q == LAST);
   assign word_o       = {byte_i, buf_q};

   // Collect the lower three bytes; the 4th is forwarded directly.
   always_ff @(posedge clk) begin
      if (clr_i) begin
         bcnt_q <= '0;
         buf_q  <= '0;
      end else if (byte_valid_i) begin
         bcnt_q <= bcnt_q + 2'd1;
         if (bcnt_q != LAST)
            buf_q[8*bcnt_q +: 8] <= byte_i;
      end
   end

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: header, words into imem, XOR checksum.
// Releases the CPU on a good image, flags a sticky error otherwise.
module prog_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_run,
   output logic              busy,
   output logic              error
);

   localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_W;

   state_e            state_q;
   logic [15:0]       cnt_q;
   logic [ADDR_W:0]   widx_q;
   logic [7:0]        csum_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              run_q;
   logic              busy_q;
   logic              err_q;

   logic              loading;
   logic              acc;
   logic [15:0]       cnt_d;
   logic [16:0]       widx_d;
   logic [7:0]        csum_d;
   logic              word_valid;
   logic [31:0]       word;

   assign loading = (state_q == HDR0) || (state_q == HDR1) ||
                    (state_q == DATA) || (state_q == CSUM);
   assign in_ready = rst && loading;
   assign acc      = in_valid && in_ready;
   assign cnt_d    = {in_data, cnt_q[7:0]};
   assign widx_d   = 17'(widx_q) + 17'd1;
   assign csum_d   = csum_q ^ in_data;

   byte_packer u_packer (
      .clk          (clk),
      .clr_i        (!rst),
      .byte_valid_i (acc && (state_q == DATA)),
      .byte_i       (in_data),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // Loader FSM with counters, checksum and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HDR0;
         cnt_q   <= '0;
         widx_q  <= '0;
         csum_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         if (acc)
            csum_q <= csum_d;
         unique case (state_q)
            HDR0: if (acc) begin
               cnt_q[7:0] <= in_data;
               busy_q     <= 1'b1;
               state_q    <= HDR1;
            end
            HDR1: if (acc) begin
               cnt_q[15:8] <= in_data;
               if (cnt_d == 16'd0) begin
                  state_q <= CSUM;
               end else if ({1'b0, cnt_d} > MAX_WORDS) begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= DATA;
               end
            end
            DATA: if (word_valid) begin
               we_q    <= 1'b1;
               addr_q  <= widx_q[ADDR_W-1:0];
               wdata_q <= word;
               widx_q  <= widx_d[ADDR_W:0];
               if (widx_d == {1'b0, cnt_q})
                  state_q <= CSUM;
            end
            CSUM: if (acc) begin
               busy_q <= 1'b0;
               if (csum_d == 8'd0) begin
                  state_q <= RUN;
                  run_q   <= 1'b1;
               end else begin
                  state_q <= ERR;
                  err_q   <= 1'b1;
               end
            end
            RUN, ERR: ;
            default: state_q <= ERR;
         endcase
      end
   end

   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign cpu_run    = run_q;
   assign busy       = busy_q;
   assign error      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good, empty, bad, oversize,
// gapped and interrupted images with a write log.
module tb_prog_loader;

   localparam int ADDR_W = 8;

   typedef logic [7:0] bq_t[$];

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_run;
   logic              busy;
   logic              error;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wc[$];
   bq_t         img1;
   bq_t         img;

   prog_loader #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_run    (cpu_run),
      .busy       (busy),
      .error      (error)
   );

   always #5 clk = ~clk;

   // Cycle counter for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   // Log every write strobe seen mid-cycle.
   always @(negedge clk) begin
      if (imem_we) begin
         wa.push_back(32'(imem_addr));
         wd.push_back(imem_wdata);
         wc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rst in_ready", 32'(in_ready), 0);
      chk("rst imem_we", 32'(imem_we), 0);
      chk("rst imem_addr", 32'(imem_addr), 0);
      chk("rst imem_wdata", imem_wdata, 0);
      chk("rst cpu_run", 32'(cpu_run), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst error", 32'(error), 0);
      rst = 1'b1;
      #1;
      chk("post-rst in_ready", 32'(in_ready), 1);
      chk("post-rst busy", 32'(busy), 0);
      wa.delete();
      wd.delete();
      wc.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit rnd);
      logic rdy;
      if (rnd) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(1, 0) == 1) begin
               @(negedge clk);
               in_valid = 1'b0;
               in_data = 8'($urandom);
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data = b;
      last_cyc = cyc;
      #1;
      rdy = in_ready;
      chk("accept", 32'(rdy), 1);
      @(posedge clk);
   endtask

   task automatic send_img(input bq_t q, input bit rnd);
      foreach (q[i]) send_byte(q[i], rnd);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
   endtask

   task automatic chk_img1_writes(input string tag);
      chk({tag, " nwr"}, 32'(wa.size()), 2);
      if (wa.size() == 2) begin
         chk({tag, " a0"}, wa[0], 0);
         chk({tag, " d0"}, wd[0], 32'h11223344);
         chk({tag, " a1"}, wa[1], 1);
         chk({tag, " d1"}, wd[1], 32'hAABBCCDD);
      end
   endtask

   initial begin
      img1 = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
               8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h46};

      // Case 1: valid two-word image, back-to-back.
      do_reset();
      send_byte(img1[0], 1'b0);
      #1;
      chk("c1 busy hdr1", 32'(busy), 1);
      for (int i = 1; i < 11; i++) send_byte(img1[i], 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk("c1 cpu_run", 32'(cpu_run), 1);
      chk("c1 error", 32'(error), 0);
      chk("c1 in_ready", 32'(in_ready), 0);
      chk("c1 busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      chk_img1_writes("c1");
      if (wc.size() == 2) begin
         chk("c1 spacing", 32'(wc[1] - wc[0]), 4);
         chk("c1 last wr at csum", 32'(wc[1]), 32'(last_cyc));
      end

      // Case 2: empty image.
      do_reset();
      img = '{8'h00, 8'h00, 8'h00};
      send_img(img, 1'b0);
      chk("c2 cpu_run", 32'(cpu_run), 1);
      chk("c2 error", 32'(error), 0);
      repeat (2) @(negedge clk);
      chk("c2 nwr", 32'(wa.size()), 0);

      // Case 3: bad checksum.
      do_reset();
      img = img1;
      img[10] = 8'h47;
      send_img(img, 1'b0);
      chk("c3 error", 32'(error), 1);
      chk("c3 cpu_run", 32'(cpu_run), 0);
      chk("c3 in_ready", 32'(in_ready), 0);
      repeat (2) @(negedge clk);
      chk_img1_writes("c3");

      // Case 4: oversize count 257.
      do_reset();
      send_byte(8'h01, 1'b0);
      send_byte(8'h01, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 8'h55;
      #1;
      chk("c4 error", 32'(error), 1);
      chk("c4 in_ready", 32'(in_ready), 0);
      repeat (4) @(negedge clk);
      #1;
      chk("c4 in_ready held", 32'(in_ready), 0);
      chk("c4 cpu_run", 32'(cpu_run), 0);
      chk("c4 nwr", 32'(wa.size()), 0);
      in_valid = 1'b0;

      // Case 5: case 1 with random valid gaps.
      do_reset();
      send_img(img1, 1'b1);
      chk("c5 cpu_run", 32'(cpu_run), 1);
      chk("c5 error", 32'(error), 0);
      chk("c5 in_ready", 32'(in_ready), 0);
      repeat (2) @(negedge clk);
      chk_img1_writes("c5");

      // Case 6: reset after 5 bytes, then full replay.
      do_reset();
      for (int i = 0; i < 5; i++) send_byte(img1[i], 1'b0);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("c6 mid in_ready", 32'(in_ready), 0);
      chk("c6 mid busy", 32'(busy), 0);
      chk("c6 mid we", 32'(imem_we), 0);
      chk("c6 mid cpu_run", 32'(cpu_run), 0);
      chk("c6 mid error", 32'(error), 0);
      rst = 1'b1;
      wa.delete();
      wd.delete();
      wc.delete();
      send_img(img1, 1'b0);
      chk("c6 cpu_run", 32'(cpu_run), 1);
      chk("c6 error", 32'(error), 0);
      repeat (2) @(negedge clk);
      chk_img1_writes("c6");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
